apb_arbiter: RTL and testbench
==============================

APB_ARBITER -- requirements
Module: apb_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, APB address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, APB data width.
REQ-003 The block SHALL have parameter TIMEOUT, default 16, maximum ACCESS cycles without pready before the block aborts the transfer.
REQ-004 The block SHALL have port clk, input, 1, single clock; all logic on the rising edge.
REQ-005 The block SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port req, input, 2, per-requester transfer request.
REQ-007 The block SHALL have port wr, input, 2, per-requester write (1) / read (0).
REQ-008 The block SHALL have ports addr0 and addr1, input, ADDR_W, requester addresses.
REQ-009 The block SHALL have ports wdata0 and wdata1, input, DATA_W, requester write data.
REQ-010 The block SHALL have port ack, output, 2, one-cycle completion pulse per requester.
REQ-011 The block SHALL have port rdata, output, DATA_W, read data, valid while ack is high.
REQ-012 The block SHALL have port err, output, 1, timeout flag, valid while ack is high.
REQ-013 The block SHALL have APB master ports: paddr (output, ADDR_W), pwdata (output, DATA_W), pwrite (output, 1), psel (output, 1), penable (output, 1), prdata (input, DATA_W) and pready (input, 1).

Function
REQ-014 The FSM SHALL have states IDLE, SETUP and ACCESS; all outputs SHALL be registered.
REQ-015 IDLE: req bits masked by the current ack are ignored; if any remaining req is set, the block SHALL pick a winner, latch its wr/addr/wdata into pwrite/paddr/pwdata and go to SETUP.
REQ-016 Arbitration SHALL be round-robin with a 1-bit priority pointer: a lone requester wins; on simultaneous requests the pointer's requester wins.
REQ-017 After each completion, whether by pready or timeout, the pointer SHALL point to the requester not just served.
REQ-018 SETUP: psel=1 and penable=0 for exactly one cycle, then ACCESS.
REQ-019 ACCESS: psel=1 and penable=1; paddr, pwdata and pwrite SHALL stay stable until exit.
REQ-020 ACCESS with pready=1 sampled: next cycle state=IDLE, psel=penable=0, ack[winner]=1, err=0, and rdata=prdata on a read (0 on a write).
REQ-021 Timeout: a counter SHALL clear on SETUP->ACCESS and increment each ACCESS cycle with pready=0.
REQ-022 When the counter reaches TIMEOUT-1 with pready=0, the next cycle SHALL be IDLE with ack[winner]=1, err=1 and rdata=0.
REQ-023 pready=1 in the same cycle as the timeout limit SHALL count as normal completion (err=0).
REQ-024 Minimum latency: req sampled in IDLE at edge N gives SETUP in N+1, ACCESS in N+2 and ack in N+3 when pready=1 on the first ACCESS cycle.
REQ-025 Requesters SHALL hold req and their inputs until ack; once latched, the transfer SHALL complete even if req drops, and changes to requester inputs SHALL be ignored.
REQ-026 ack, err and rdata SHALL be held for exactly one cycle, then return to 0.
REQ-027 ack SHALL be one-hot or zero; at most one APB transfer SHALL be outstanding.
REQ-028 prdata and pready SHALL be ignored outside ACCESS.

Reset
REQ-029 rstn low SHALL immediately force state=IDLE, pointer=0, counter=0, and ack, err, rdata, paddr, pwdata, pwrite, psel, penable all 0.
REQ-030 Reset asserted mid-transfer SHALL abort the transfer with no ack; the first grant after rstn deasserts SHALL follow REQ-015.

Verification
REQ-031 The bench SHALL cover a single read: req=2'b01, wr=0, addr0=0x10, pready=1, prdata=0xCAFE -> psel rises at +1, penable at +2, ack=2'b01 with rdata=0xCAFE at +3, err=0.
REQ-032 The bench SHALL cover simultaneous requests after reset: req=2'b11 held -> requester 0 served first, then requester 1, then requester 0; ack pulses alternate.
REQ-033 The bench SHALL cover wait states: write, wdata1=0x55, pready low 3 ACCESS cycles -> paddr, pwdata and penable stable throughout, ack=2'b10 one cycle after pready, rdata=0.
REQ-034 The bench SHALL cover timeout: TIMEOUT=4, pready held 0 -> ACCESS lasts 4 cycles, then ack pulse with err=1 and rdata=0.
REQ-035 The bench SHALL cover reset mid-transfer: rstn low in ACCESS -> psel, penable and ack drop to 0 asynchronously; after release with req=2'b10 the next grant goes to requester 1.
REQ-036 The bench SHALL cover a requester dropping req: req0 deasserted during SETUP -> transfer still completes with ack=2'b01.

Source files
------------

// File: rtl/apb_arbiter.sv
// apb_arbiter: two-requester round-robin arbiter driving a single APB master port.
// Transfers go IDLE -> SETUP -> ACCESS. A transfer completes on pready or is aborted
// after TIMEOUT ACCESS cycles. Completion is a one-cycle ack/err/rdata pulse.
module apb_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [1:0]        req,
  input  logic [1:0]        wr,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        ack,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic              pwrite,
  output logic              psel,
  output logic              penable,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready
);

  // The counter only has to reach TIMEOUT-1.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t              r_state, w_nxt_state;
  logic                r_ptr, w_nxt_ptr;
  logic                r_win, w_nxt_win;
  logic [CNT_W-1:0]    r_cnt, w_nxt_cnt;
  logic [ADDR_W-1:0]   r_paddr, w_nxt_paddr;
  logic [DATA_W-1:0]   r_pwdata, w_nxt_pwdata;
  logic                r_pwrite, w_nxt_pwrite;
  logic                r_psel, w_nxt_psel;
  logic                r_penable, w_nxt_penable;
  logic [1:0]          r_ack, w_nxt_ack;
  logic                r_err, w_nxt_err;
  logic [DATA_W-1:0]   r_rdata, w_nxt_rdata;

  logic [1:0]          w_req;
  logic                w_grant;

  assign ack     = r_ack;
  assign err     = r_err;
  assign rdata   = r_rdata;
  assign paddr   = r_paddr;
  assign pwdata  = r_pwdata;
  assign pwrite  = r_pwrite;
  assign psel    = r_psel;
  assign penable = r_penable;

  // State and all registered outputs; reset clears everything immediately.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_ptr     <= 1'b0;
      r_win     <= 1'b0;
      r_cnt     <= '0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_pwrite  <= 1'b0;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_ack     <= '0;
      r_err     <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_state   <= w_nxt_state;
      r_ptr     <= w_nxt_ptr;
      r_win     <= w_nxt_win;
      r_cnt     <= w_nxt_cnt;
      r_paddr   <= w_nxt_paddr;
      r_pwdata  <= w_nxt_pwdata;
      r_pwrite  <= w_nxt_pwrite;
      r_psel    <= w_nxt_psel;
      r_penable <= w_nxt_penable;
      r_ack     <= w_nxt_ack;
      r_err     <= w_nxt_err;
      r_rdata   <= w_nxt_rdata;
    end
  end

  // Next-state and next-output logic; the completion pulse defaults to zero every cycle.
  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_ptr     = r_ptr;
    w_nxt_win     = r_win;
    w_nxt_cnt     = r_cnt;
    w_nxt_paddr   = r_paddr;
    w_nxt_pwdata  = r_pwdata;
    w_nxt_pwrite  = r_pwrite;
    w_nxt_psel    = r_psel;
    w_nxt_penable = r_penable;
    w_nxt_ack     = '0;
    w_nxt_err     = 1'b0;
    w_nxt_rdata   = '0;

    // A requester whose ack is showing this cycle has not yet dropped req; ignore it.
    w_req   = req & ~r_ack;
    // Lone requester wins outright; a tie goes to the pointer.
    w_grant = (w_req == 2'b11) ? r_ptr : w_req[1];

    case (r_state)
      IDLE: begin
        if (|w_req) begin
          w_nxt_win     = w_grant;
          w_nxt_paddr   = w_grant ? addr1  : addr0;
          w_nxt_pwdata  = w_grant ? wdata1 : wdata0;
          w_nxt_pwrite  = wr[w_grant];
          w_nxt_psel    = 1'b1;
          w_nxt_penable = 1'b0;
          w_nxt_state   = SETUP;
        end
      end
      SETUP: begin
        w_nxt_penable = 1'b1;
        w_nxt_cnt     = '0;
        w_nxt_state   = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          // pready wins over the timeout limit in the same cycle.
          w_nxt_state   = IDLE;
          w_nxt_psel    = 1'b0;
          w_nxt_penable = 1'b0;
          w_nxt_ack     = r_win ? 2'b10 : 2'b01;
          w_nxt_rdata   = r_pwrite ? '0 : prdata;
          w_nxt_ptr     = ~r_win;
        end else if (r_cnt == CNT_MAX) begin
          w_nxt_state   = IDLE;
          w_nxt_psel    = 1'b0;
          w_nxt_penable = 1'b0;
          w_nxt_ack     = r_win ? 2'b10 : 2'b01;
          w_nxt_err     = 1'b1;
          w_nxt_ptr     = ~r_win;
        end else begin
          w_nxt_cnt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_nxt_state   = IDLE;
        w_nxt_psel    = 1'b0;
        w_nxt_penable = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_apb_arbiter.sv
// tb_apb_arbiter: directed vectors with hand-computed expectations for apb_arbiter (TIMEOUT=4).
module tb_apb_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk;
  logic          rstn;
  logic [1:0]    req, wr;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic [1:0]    ack;
  logic [DW-1:0] rdata;
  logic          err;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic          pwrite, psel, penable;
  logic [DW-1:0] prdata;
  logic          pready;

  int n_chk = 0;
  int n_err = 0;

  apb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(4)) dut (
    .clk(clk), .rstn(rstn), .req(req), .wr(wr),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack(ack), .rdata(rdata), .err(err),
    .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite),
    .psel(psel), .penable(penable), .prdata(prdata), .pready(pready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for an ack pulse; returns the ack seen and cycles taken.
  task automatic wait_ack(output logic [1:0] a, output int n);
    a = 2'b00;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      n++;
      if (ack != 2'b00) begin
        a = ack;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  logic [1:0] a;
  int         n;

  initial begin
    rstn = 1'b0; req = '0; wr = '0; addr0 = '0; addr1 = '0;
    wdata0 = '0; wdata1 = '0; prdata = '0; pready = 1'b0;
    #12;
    chk("rst_ctl",    {ack, err, psel, penable, pwrite}, 0);
    chk("rst_paddr",  paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_rdata",  rdata, 0);
    @(negedge clk);
    rstn = 1'b1;
    tick();

    // Single read from requester 0, minimum latency.
    req = 2'b01; wr = 2'b00; addr0 = 'h10; pready = 1'b1; prdata = 'hCAFE;
    tick();
    chk("rd_setup_sel", {psel, penable}, 2'b10);
    chk("rd_setup_addr", paddr, 'h10);
    tick();
    chk("rd_access_sel", {psel, penable}, 2'b11);
    tick();
    chk("rd_ack",   ack, 2'b01);
    chk("rd_rdata", rdata, 'hCAFE);
    chk("rd_err",   err, 0);
    chk("rd_idle",  {psel, penable}, 2'b00);
    req = 2'b00;
    tick();
    chk("rd_ack_drop",   ack, 2'b00);
    chk("rd_rdata_drop", rdata, 0);

    // Simultaneous requests after reset: 0, 1, 0.
    do_reset();
    req = 2'b11; wr = 2'b00; addr0 = 'h100; addr1 = 'h200; prdata = 'h1111; pready = 1'b1;
    wait_ack(a, n);
    chk("rr_ack0", a, 2'b01);
    chk("rr_lat0", n, 3);
    wait_ack(a, n);
    chk("rr_ack1", a, 2'b10);
    chk("rr_lat1", n, 3);
    chk("rr_addr1", paddr, 'h200);
    wait_ack(a, n);
    chk("rr_ack2", a, 2'b01);
    chk("rr_lat2", n, 3);
    req = 2'b00;
    tick();

    // Write with three wait states; pready lands on the timeout-limit cycle.
    req = 2'b10; wr = 2'b10; addr1 = 'h44; wdata1 = 'h55; pready = 1'b0; prdata = 'hAAAA;
    tick();
    chk("ws_setup", {psel, penable}, 2'b10);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ws_sel",    {psel, penable}, 2'b11);
      chk("ws_paddr",  paddr, 'h44);
      chk("ws_pwdata", pwdata, 'h55);
      chk("ws_pwrite", pwrite, 1);
      chk("ws_noack",  ack, 2'b00);
      if (i == 1) begin addr1 = 'hFF; wdata1 = 'h0; wr = 2'b00; end
      if (i == 3) pready = 1'b1;
    end
    tick();
    chk("ws_ack",   ack, 2'b10);
    chk("ws_err",   err, 0);
    chk("ws_rdata", rdata, 0);
    req = 2'b00; pready = 1'b0;
    tick();

    // Timeout: pready never comes.
    req = 2'b01; wr = 2'b00; addr0 = 'h8; pready = 1'b0; prdata = 'hDEAD;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("to_access", {psel, penable}, 2'b11);
      chk("to_noack",  ack, 2'b00);
    end
    tick();
    chk("to_ack",   ack, 2'b01);
    chk("to_err",   err, 1);
    chk("to_rdata", rdata, 0);
    chk("to_idle",  {psel, penable}, 2'b00);
    req = 2'b00;
    tick();
    chk("to_drop", {ack, err}, 0);

    // Reset in the middle of ACCESS.
    req = 2'b01; pready = 1'b0;
    tick();
    tick();
    chk("mr_access", {psel, penable}, 2'b11);
    #3;
    rstn = 1'b0;
    #1;
    chk("mr_async", {psel, penable, ack}, 0);
    req = 2'b10; wr = 2'b00; addr1 = 'h70; prdata = 'hBEEF; pready = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
    wait_ack(a, n);
    chk("mr_ack",   a, 2'b10);
    chk("mr_lat",   n, 3);
    chk("mr_rdata", rdata, 'hBEEF);
    req = 2'b00;
    tick();

    // Requester drops req during SETUP.
    req = 2'b01; wr = 2'b00; addr0 = 'h20; prdata = 'h1234; pready = 1'b1;
    tick();
    req = 2'b00; addr0 = 'h99;
    tick();
    chk("dr_paddr", paddr, 'h20);
    tick();
    chk("dr_ack",   ack, 2'b01);
    chk("dr_rdata", rdata, 'h1234);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
